// File: rtl/gfx_fpint_arbiter.sv
// Round-robin arbiter sharing one gfx_fpint pipeline; a LATENCY-deep scoreboard routes writebacks.
// Define GFX_FPINT_ARB_PRIO_EN to give requester 0 strict priority over the round-robin group.
module gfx_fpint_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LATENCY = 8,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned OP_W    = 8,
  localparam int unsigned SelW   = $clog2(NUM_REQ),
  localparam int unsigned CntW   = $clog2(LATENCY + 1)
) (
  input  logic                            clk,
  input  logic                            srst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0][OP_W-1:0]    req_op,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]   req_tag,
  input  logic                            flush,
  output logic                            issue_valid,
  output logic [OP_W-1:0]                 issue_op,
  output logic [SelW-1:0]                 issue_sel,
  output logic                            fpint_abort,
  input  logic                            wb_valid,
  output logic [NUM_REQ-1:0]              resp_valid,
  output logic [TAG_W-1:0]                resp_tag,
  output logic                            err_desync
);

  logic [SelW-1:0]    rr_q, rr_d;
  logic               gnt_found, accept, rr_adv;
  logic [SelW-1:0]    gnt_idx, scan_sel;
  int unsigned        scan_idx;

  logic               issue_valid_q;
  logic [OP_W-1:0]    issue_op_q;
  logic [SelW-1:0]    issue_sel_q;
  logic [TAG_W-1:0]   issue_tag_q;

  logic [LATENCY-1:0] sb_v_q;
  logic [SelW-1:0]    sb_id_q  [LATENCY];
  logic [TAG_W-1:0]   sb_tag_q [LATENCY];

  logic [CntW-1:0]    shadow_q;
  logic               abort_q, err_q, err_d, cmp_mask;
  logic [NUM_REQ-1:0] resp_valid_q, resp_d;
  logic [TAG_W-1:0]   resp_tag_q;

  logic               head_v;
  logic [SelW-1:0]    head_id;
  logic [TAG_W-1:0]   head_tag;

  // Scan upward from the rr pointer; with priority enabled requester 0 pre-empts the scan.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = 0;
    scan_sel  = '0;
`ifdef GFX_FPINT_ARB_PRIO_EN
    if (req_valid[0]) gnt_found = 1'b1;
`endif
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_idx = (32'(rr_q) + i) % NUM_REQ;
      scan_sel = SelW'(scan_idx);
      if (!gnt_found && req_valid[scan_sel]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_sel;
      end
    end
  end

  assign accept = gnt_found & ~flush & ~srst;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    rr_d   = rr_q;
    rr_adv = accept;
`ifdef GFX_FPINT_ARB_PRIO_EN
    rr_adv = accept && (gnt_idx != '0);
`endif
    if (rr_adv) rr_d = (gnt_idx == SelW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  assign head_v   = sb_v_q[LATENCY-1];
  assign head_id  = sb_id_q[LATENCY-1];
  assign head_tag = sb_tag_q[LATENCY-1];

  // Writebacks of aborted ops may still trickle out for LATENCY cycles after a flush.
  assign cmp_mask = flush | (shadow_q != '0);

  always_comb begin
    resp_d = '0;
    if (head_v && wb_valid && !flush) resp_d[head_id] = 1'b1;
    err_d = err_q | (!cmp_mask && (head_v != wb_valid));
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      rr_q          <= '0;
      issue_valid_q <= 1'b0;
      issue_op_q    <= '0;
      issue_sel_q   <= '0;
      issue_tag_q   <= '0;
      sb_v_q        <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        sb_id_q[i]  <= '0;
        sb_tag_q[i] <= '0;
      end
      shadow_q      <= '0;
      abort_q       <= 1'b0;
      resp_valid_q  <= '0;
      resp_tag_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      rr_q          <= rr_d;
      issue_valid_q <= accept;
      if (accept) begin
        issue_op_q  <= req_op[gnt_idx];
        issue_sel_q <= gnt_idx;
        issue_tag_q <= req_tag[gnt_idx];
      end
      sb_v_q[0]   <= issue_valid_q & ~flush;
      sb_id_q[0]  <= issue_sel_q;
      sb_tag_q[0] <= issue_tag_q;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        sb_v_q[i]   <= sb_v_q[i-1] & ~flush;
        sb_id_q[i]  <= sb_id_q[i-1];
        sb_tag_q[i] <= sb_tag_q[i-1];
      end
      if (flush)                 shadow_q <= CntW'(LATENCY);
      else if (shadow_q != '0)   shadow_q <= shadow_q - 1'b1;
      abort_q      <= flush;
      resp_valid_q <= resp_d;
      if (|resp_d) resp_tag_q <= head_tag;
      err_q        <= err_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_op    = issue_op_q;
  assign issue_sel   = issue_sel_q;
  assign fpint_abort = abort_q;
  assign resp_valid  = resp_valid_q;
  assign resp_tag    = resp_tag_q;
  assign err_desync  = err_q;

endmodule

// File: tb/tb_gfx_fpint_arbiter.sv
// Scoreboard bench for gfx_fpint_arbiter: directed grants, a fixed-latency fpint model,
// and monitors that pop expected issues/responses as the DUT presents them.
module tb_gfx_fpint_arbiter;

  logic             clk = 1'b0;
  logic             srst;
  logic [3:0]       req_valid;
  logic [3:0]       req_ready;
  logic [3:0][7:0]  req_op;
  logic [3:0][5:0]  req_tag;
  logic             flush;
  logic             issue_valid;
  logic [7:0]       issue_op;
  logic [1:0]       issue_sel;
  logic             fpint_abort;
  logic             wb_valid;
  logic [3:0]       resp_valid;
  logic [5:0]       resp_tag;
  logic             err_desync;

  logic             wb_force;
  logic [7:0]       fp_pipe = '0;
  int               cyc = 0;
  int               n_checks = 0;
  int               n_pass = 0;

  typedef struct { int due; logic [1:0] sel; logic [7:0] op; } iss_t;
  typedef struct { int due; logic [3:0] oh; logic [5:0] tag; } resp_t;
  iss_t  iss_q[$];
  resp_t resp_q[$];
  iss_t  iss_e;
  resp_t resp_e;

  gfx_fpint_arbiter dut (
    .clk        (clk),
    .srst       (srst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_tag    (req_tag),
    .flush      (flush),
    .issue_valid(issue_valid),
    .issue_op   (issue_op),
    .issue_sel  (issue_sel),
    .fpint_abort(fpint_abort),
    .wb_valid   (wb_valid),
    .resp_valid (resp_valid),
    .resp_tag   (resp_tag),
    .err_desync (err_desync)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // fpint stand-in: fixed 8-cycle latency, ignores abort so flushed ops still write back.
  always @(posedge clk) fp_pipe <= {fp_pipe[6:0], issue_valid === 1'b1};
  assign wb_valid = fp_pipe[7] | wb_force;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    logic [1:0] r = '0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  always @(negedge clk) begin
    if (issue_valid === 1'b1) begin
      if (iss_q.size() == 0) check("issue_unexpected", 32'(issue_sel), 32'hFFFF);
      else begin
        iss_e = iss_q.pop_front();
        check("issue_sel", 32'(issue_sel), 32'(iss_e.sel));
        check("issue_op", 32'(issue_op), 32'(iss_e.op));
        check("issue_cycle", 32'(cyc), 32'(iss_e.due));
      end
    end
  end

  always @(negedge clk) begin
    if (resp_valid !== 4'b0 && resp_valid !== 4'bx) begin
      if (resp_q.size() == 0) check("resp_unexpected", 32'(resp_valid), 32'h0);
      else begin
        resp_e = resp_q.pop_front();
        check("resp_valid", 32'(resp_valid), 32'(resp_e.oh));
        check("resp_tag", 32'(resp_tag), 32'(resp_e.tag));
        check("resp_cycle", 32'(cyc), 32'(resp_e.due));
      end
    end
  end

  // One cycle of request stimulus with the hand-computed grant.
  task automatic drive(input logic [3:0] v, input logic [3:0] exp_rdy, input bit want_resp);
    logic [1:0] g;
    req_valid = v;
    @(negedge clk);
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (exp_rdy != 4'b0) begin
      g = oh2idx(exp_rdy);
      iss_q.push_back('{due: cyc + 1, sel: g, op: req_op[g]});
      if (want_resp) resp_q.push_back('{due: cyc + 10, oh: exp_rdy, tag: req_tag[g]});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    req_valid = 4'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk_err(input string name, input logic exp);
    @(negedge clk);
    check(name, 32'(err_desync), 32'(exp));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    srst = 1'b1;
    req_valid = 4'b0;
    repeat (2) @(posedge clk);
    #1 srst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1);
  end

  initial begin
    srst = 1'b1;
    flush = 1'b0;
    wb_force = 1'b0;
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      req_op[i]  = 8'hA0 + 8'(i);
      req_tag[i] = 6'h08 + 6'(i);
    end

    // Reset: srst dominates a full request vector, then everything reads zero.
    @(posedge clk); #1;
    @(negedge clk);
    check("srst_blocks_grant", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    srst = 1'b0;
    req_valid = 4'b0;
    @(negedge clk);
    check("rst_issue_valid", 32'(issue_valid), 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_err", 32'(err_desync), 32'h0);
    check("rst_abort", 32'(fpint_abort), 32'h0);
    check("rst_issue_sel", 32'(issue_sel), 32'h0);
    @(posedge clk); #1;

    // All four requesting: 0,1,2,3,0.
    drive(4'b1111, 4'b0001, 1'b1);
    drive(4'b1111, 4'b0010, 1'b1);
    drive(4'b1111, 4'b0100, 1'b1);
    drive(4'b1111, 4'b1000, 1'b1);
    drive(4'b1111, 4'b0001, 1'b1);
    idle(12);
    chk_err("err_after_rr", 1'b0);

    // Single requester 2 with tag 0x15; pointer ends at 3.
    req_tag[2] = 6'h15;
    drive(4'b0100, 4'b0100, 1'b1);
    idle(12);
    chk_err("err_after_single", 1'b0);

    // Wrap-around from pointer 3.
    drive(4'b1001, 4'b1000, 1'b1);
    drive(4'b1001, 4'b0001, 1'b1);
    drive(4'b1001, 4'b1000, 1'b1);
    idle(12);

    // Three ops, flush two cycles after the first issue; none may respond.
    drive(4'b1111, 4'b0001, 1'b0);
    drive(4'b1111, 4'b0010, 1'b0);
    drive(4'b1111, 4'b0100, 1'b0);
    flush = 1'b1;
    drive(4'b1111, 4'b0000, 1'b0);
    flush = 1'b0;
    req_valid = 4'b0;
    @(negedge clk);
    check("abort_high", 32'(fpint_abort), 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_low", 32'(fpint_abort), 32'h0);
    @(posedge clk); #1;
    idle(10);
    chk_err("err_flush_window", 1'b0);
    drive(4'b0001, 4'b0001, 1'b1);
    idle(12);
    chk_err("err_after_flush_op", 1'b0);

    // Stray writeback with empty scoreboard: sticky error until srst.
    wb_force = 1'b1;
    @(negedge clk);
    check("err_not_yet", 32'(err_desync), 32'h0);
    @(posedge clk); #1;
    wb_force = 1'b0;
    chk_err("err_set", 1'b1);
    idle(3);
    chk_err("err_sticky", 1'b1);
    do_reset();
    chk_err("err_cleared", 1'b0);

    // srst mid-flight discards the op; its late writeback is a desync.
    drive(4'b0010, 4'b0010, 1'b0);
    do_reset();
    idle(10);
    chk_err("err_after_midflight_rst", 1'b1);
    do_reset();
    chk_err("err_cleared2", 1'b0);

`ifdef GFX_FPINT_ARB_PRIO_EN
    drive(4'b0111, 4'b0001, 1'b1);
    drive(4'b0111, 4'b0001, 1'b1);
    drive(4'b0111, 4'b0001, 1'b1);
`else
    drive(4'b0111, 4'b0001, 1'b1);
    drive(4'b0111, 4'b0010, 1'b1);
    drive(4'b0111, 4'b0100, 1'b1);
`endif
    drive(4'b0110, 4'b0010, 1'b1);
    drive(4'b0110, 4'b0100, 1'b1);
    drive(4'b0110, 4'b0010, 1'b1);
    idle(12);
    chk_err("err_final", 1'b0);

    check("iss_q_drained", 32'(iss_q.size()), 32'h0);
    check("resp_q_drained", 32'(resp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
